// File: rtl/hdmi_pixel_pipe.sv
// Pixel-stream stage between HDMI decoder and encoder: fixed-latency video delay,
// frame-synchronous pixel processing (pass/invert/fill/ramp) and input frame timing measurement.
module hdmi_pixel_pipe #(
    parameter int CHANNELS   = 3,
    parameter int CH_WIDTH   = 8,
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                         p_clock,
    input  logic                         reset_n,
    input  logic [1:0]                   mode,
    input  logic [CHANNELS*CH_WIDTH-1:0] fill_colour,
    input  logic [2:0]                   sync_in,
    input  logic [CHANNELS*CH_WIDTH-1:0] rgb_in,
    output logic [2:0]                   sync_out,
    output logic [CHANNELS*CH_WIDTH-1:0] rgb_out,
    output logic [1:0]                   active_mode,
    output logic [CNT_WIDTH-1:0]         frame_width,
    output logic [CNT_WIDTH-1:0]         frame_height,
    output logic                         timing_valid,
    output logic                         frame_start
);

    localparam int PW = CHANNELS * CH_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_FILL = 2'd2,
        MODE_RAMP = 2'd3
    } mode_e;

    logic                 r_vsync_d;
    logic                 r_de_d;
    logic [1:0]           r_active_mode;
    logic [CNT_WIDTH-1:0] r_x_cnt;
    logic [CNT_WIDTH-1:0] r_y_cnt;
    logic [CNT_WIDTH-1:0] r_ref_len;
    logic                 r_have_ref;
    logic                 r_mismatch;
    logic [CNT_WIDTH-1:0] r_frame_width;
    logic [CNT_WIDTH-1:0] r_frame_height;
    logic                 r_timing_valid;
    logic                 r_frame_start;
    logic [PW-1:0]        r_rgb_pipe  [PIPE_DEPTH];
    logic [2:0]           r_sync_pipe [PIPE_DEPTH];

    logic                 w_vsync;
    logic                 w_de;
    logic                 w_vs_rise;
    logic                 w_de_fall;
    logic [1:0]           w_mode_eff;
    logic [CNT_WIDTH-1:0] w_x_next;
    logic [CNT_WIDTH-1:0] w_y_next;
    logic [CNT_WIDTH-1:0] w_y_cur;
    logic [CNT_WIDTH-1:0] w_ref_next;
    logic                 w_line_mis;
    logic                 w_mis_cur;
    logic [PW-1:0]        w_pix;

    assign w_vsync    = sync_in[2];
    assign w_de       = sync_in[0];
    assign w_vs_rise  = w_vsync & ~r_vsync_d;
    assign w_de_fall  = ~w_de & r_de_d;

    // The mode sampled on vsync rise already governs the pixel entering in that cycle.
    assign w_mode_eff = w_vs_rise ? mode : r_active_mode;

    assign w_x_next   = (r_x_cnt == CNT_MAX) ? r_x_cnt : r_x_cnt + 1'b1;
    assign w_y_next   = (r_y_cnt == CNT_MAX) ? r_y_cnt : r_y_cnt + 1'b1;

    // Frame-close values include a line that ends in the same cycle as the vsync rise.
    assign w_line_mis = w_de_fall & r_have_ref & (r_x_cnt != r_ref_len);
    assign w_ref_next = (w_de_fall & ~r_have_ref) ? r_x_cnt : r_ref_len;
    assign w_y_cur    = w_de_fall ? w_y_next : r_y_cnt;
    assign w_mis_cur  = r_mismatch | w_line_mis;

    always_ff @(posedge p_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vsync_d      <= 1'b0;
            r_de_d         <= 1'b0;
            r_active_mode  <= 2'd0;
            r_x_cnt        <= '0;
            r_y_cnt        <= '0;
            r_ref_len      <= '0;
            r_have_ref     <= 1'b0;
            r_mismatch     <= 1'b0;
            r_frame_width  <= '0;
            r_frame_height <= '0;
            r_timing_valid <= 1'b0;
            r_frame_start  <= 1'b0;
        end else begin
            r_vsync_d     <= w_vsync;
            r_de_d        <= w_de;
            r_frame_start <= w_vs_rise;
            r_x_cnt       <= w_de ? w_x_next : '0;
            r_ref_len     <= w_ref_next;
            if (w_vs_rise) begin
                r_active_mode  <= mode;
                r_frame_height <= w_y_cur;
                r_frame_width  <= w_ref_next;
                r_timing_valid <= (w_y_cur != '0) & ~w_mis_cur;
                r_y_cnt        <= '0;
                r_mismatch     <= 1'b0;
                r_have_ref     <= 1'b0;
            end else begin
                if (w_de_fall) begin
                    r_y_cnt    <= w_y_next;
                    r_have_ref <= 1'b1;
                end
                r_mismatch <= w_mis_cur;
            end
        end
    end

    always_comb begin
        w_pix = '0;
        if (w_de) begin
            case (w_mode_eff)
                MODE_PASS: w_pix = rgb_in;
                MODE_INV:  w_pix = ~rgb_in;
                MODE_FILL: w_pix = fill_colour;
                MODE_RAMP: begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        w_pix[k*CH_WIDTH +: CH_WIDTH] = r_x_cnt[CH_WIDTH-1:0];
                    end
                end
                default:   w_pix = '0;
            endcase
        end
    end

    // Stage 0 holds the processed pixel; the remaining stages are plain delay.
    always_ff @(posedge p_clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_rgb_pipe[i]  <= '0;
                r_sync_pipe[i] <= '0;
            end
        end else begin
            r_rgb_pipe[0]  <= w_pix;
            r_sync_pipe[0] <= sync_in;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_rgb_pipe[i]  <= r_rgb_pipe[i-1];
                r_sync_pipe[i] <= r_sync_pipe[i-1];
            end
        end
    end

    assign rgb_out      = r_rgb_pipe[PIPE_DEPTH-1];
    assign sync_out     = r_sync_pipe[PIPE_DEPTH-1];
    assign active_mode  = r_active_mode;
    assign frame_width  = r_frame_width;
    assign frame_height = r_frame_height;
    assign timing_valid = r_timing_valid;
    assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_hdmi_pixel_pipe.sv
// Self-checking bench for hdmi_pixel_pipe: a behavioural model fills a scoreboard as
// stimulus is driven; a negedge monitor pops and compares; scenario tasks check timing outputs.
module tb_hdmi_pixel_pipe;

    localparam int PD = 2;

    typedef struct packed {
        logic [2:0]  s;
        logic [23:0] p;
    } exp_t;

    logic        p_clock = 1'b0;
    logic        reset_n;
    logic [1:0]  mode;
    logic [23:0] fill_colour;
    logic [2:0]  sync_in;
    logic [23:0] rgb_in;
    logic [2:0]  sync_out;
    logic [23:0] rgb_out;
    logic [1:0]  active_mode;
    logic [11:0] frame_width;
    logic [11:0] frame_height;
    logic        timing_valid;
    logic        frame_start;

    hdmi_pixel_pipe #(
        .CHANNELS(3), .CH_WIDTH(8), .PIPE_DEPTH(PD), .CNT_WIDTH(12)
    ) dut (
        .p_clock(p_clock), .reset_n(reset_n), .mode(mode), .fill_colour(fill_colour),
        .sync_in(sync_in), .rgb_in(rgb_in), .sync_out(sync_out), .rgb_out(rgb_out),
        .active_mode(active_mode), .frame_width(frame_width), .frame_height(frame_height),
        .timing_valid(timing_valid), .frame_start(frame_start)
    );

    always #5 p_clock = ~p_clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb[$];
    bit          sb_en = 1'b0;
    logic [1:0]  drv_mode = 2'd0;
    logic [23:0] drv_fill = 24'h0;
    logic        m_vs = 1'b0;
    logic [11:0] m_x = '0;
    logic [1:0]  m_mode = 2'd0;
    logic        exp_fs = 1'b0;

    // Scoreboard monitor: each negedge shows the input driven PD cycles earlier.
    always @(negedge p_clock) begin
        exp_t e;
        if (sb_en && reset_n) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_empty: got no expectation, required one queued");
            end else begin
                n_pass++;
                e = sb.pop_front();
                n_checks++;
                if (sync_out !== e.s)
                    $display("FAIL sync_out @%0t: got %b required %b", $time, sync_out, e.s);
                else n_pass++;
                n_checks++;
                if (rgb_out !== e.p)
                    $display("FAIL rgb_out @%0t: got %h required %h", $time, rgb_out, e.p);
                else n_pass++;
            end
            n_checks++;
            if (frame_start !== exp_fs)
                $display("FAIL frame_start @%0t: got %b required %b", $time, frame_start, exp_fs);
            else n_pass++;
        end
    end

    task automatic step(input logic [2:0] s, input logic [23:0] pix);
        logic        vr;
        logic [23:0] p;
        exp_t        e;
        @(negedge p_clock);
        #1;
        mode        = drv_mode;
        fill_colour = drv_fill;
        sync_in     = s;
        rgb_in      = pix;
        vr = s[2] & ~m_vs;
        if (vr) m_mode = drv_mode;
        p = '0;
        if (s[0]) begin
            case (m_mode)
                2'd0:    p = pix;
                2'd1:    p = ~pix;
                2'd2:    p = drv_fill;
                default: p = {3{m_x[7:0]}};
            endcase
        end
        e.s = s;
        e.p = p;
        sb.push_back(e);
        exp_fs = vr;
        m_vs   = s[2];
        m_x    = s[0] ? ((m_x == 12'hFFF) ? m_x : m_x + 12'd1) : 12'd0;
    endtask

    task automatic line(input int px, input logic [23:0] pix);
        for (int i = 0; i < px; i++) step(3'b001, pix);
        step(3'b000, pix);
        step(3'b010, pix);
        step(3'b010, pix);
        step(3'b000, pix);
    endtask

    task automatic run_frame(input int lines, input int px, input int odd_idx,
                             input int odd_px, input logic [23:0] pix);
        for (int l = 0; l < lines; l++) line((l == odd_idx) ? odd_px : px, pix);
    endtask

    task automatic vsync_pulse(input logic [23:0] pix);
        step(3'b100, pix);
        step(3'b100, pix);
        repeat (3) step(3'b000, pix);
    endtask

    // Called with reset_n low; releases it on a negedge and re-seeds model and scoreboard.
    task automatic release_reset();
        sync_in = '0;
        rgb_in  = '0;
        repeat (2) @(negedge p_clock);
        reset_n = 1'b1;
        sb.delete();
        for (int i = 0; i < PD; i++) sb.push_back('0);
        m_vs = 1'b0; m_x = '0; m_mode = 2'd0; exp_fs = 1'b0;
        #1 sb_en = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (sync_out !== 3'b000) $display("FAIL rst_sync_out: got %b required 000", sync_out); else n_pass++;
        n_checks++; if (rgb_out !== 24'h0) $display("FAIL rst_rgb_out: got %h required 000000", rgb_out); else n_pass++;
        n_checks++; if (active_mode !== 2'd0) $display("FAIL rst_active_mode: got %0d required 0", active_mode); else n_pass++;
        n_checks++; if (frame_width !== 12'd0) $display("FAIL rst_frame_width: got %0d required 0", frame_width); else n_pass++;
        n_checks++; if (frame_height !== 12'd0) $display("FAIL rst_frame_height: got %0d required 0", frame_height); else n_pass++;
        n_checks++; if (timing_valid !== 1'b0) $display("FAIL rst_timing_valid: got %b required 0", timing_valid); else n_pass++;
        n_checks++; if (frame_start !== 1'b0) $display("FAIL rst_frame_start: got %b required 0", frame_start); else n_pass++;
        release_reset();
    endtask

    task automatic test_pass();
        drv_mode = 2'd0;
        vsync_pulse(24'h123456);
        run_frame(4, 8, -1, 0, 24'h123456);
        vsync_pulse(24'h123456);
        n_checks++; if (active_mode !== 2'd0) $display("FAIL pass_active_mode: got %0d required 0", active_mode); else n_pass++;
        n_checks++; if (frame_width !== 12'd8) $display("FAIL pass_frame_width: got %0d required 8", frame_width); else n_pass++;
        n_checks++; if (frame_height !== 12'd4) $display("FAIL pass_frame_height: got %0d required 4", frame_height); else n_pass++;
    endtask

    task automatic test_invert();
        line(8, 24'h00FF0F);
        drv_mode = 2'd1;
        line(8, 24'h00FF0F);
        n_checks++; if (active_mode !== 2'd0) $display("FAIL inv_mode_held: got %0d required 0", active_mode); else n_pass++;
        vsync_pulse(24'h00FF0F);
        n_checks++; if (active_mode !== 2'd1) $display("FAIL inv_mode_applied: got %0d required 1", active_mode); else n_pass++;
        run_frame(2, 8, -1, 0, 24'h00FF0F);
    endtask

    task automatic test_ramp_fill();
        drv_mode = 2'd3;
        vsync_pulse(24'h5A5A5A);
        n_checks++; if (active_mode !== 2'd3) $display("FAIL ramp_active_mode: got %0d required 3", active_mode); else n_pass++;
        run_frame(2, 300, -1, 0, 24'h5A5A5A);
        drv_mode = 2'd2;
        drv_fill = 24'hABCDEF;
        vsync_pulse(24'h123456);
        n_checks++; if (frame_width !== 12'd300) $display("FAIL ramp_frame_width: got %0d required 300", frame_width); else n_pass++;
        n_checks++; if (frame_height !== 12'd2) $display("FAIL ramp_frame_height: got %0d required 2", frame_height); else n_pass++;
        n_checks++; if (active_mode !== 2'd2) $display("FAIL fill_active_mode: got %0d required 2", active_mode); else n_pass++;
        run_frame(2, 8, -1, 0, 24'h123456);
    endtask

    task automatic test_timing();
        drv_mode = 2'd0;
        vsync_pulse(24'h010203);
        run_frame(6, 10, -1, 0, 24'h010203);
        vsync_pulse(24'h010203);
        n_checks++; if (frame_width !== 12'd10) $display("FAIL tim_frame_width: got %0d required 10", frame_width); else n_pass++;
        n_checks++; if (frame_height !== 12'd6) $display("FAIL tim_frame_height: got %0d required 6", frame_height); else n_pass++;
        n_checks++; if (timing_valid !== 1'b1) $display("FAIL tim_valid: got %b required 1", timing_valid); else n_pass++;
        n_checks++; if (frame_start !== 1'b0) $display("FAIL tim_fs_low: got %b required 0", frame_start); else n_pass++;
    endtask

    task automatic test_mismatch();
        run_frame(6, 10, 3, 9, 24'h0F0F0F);
        vsync_pulse(24'h0F0F0F);
        n_checks++; if (timing_valid !== 1'b0) $display("FAIL mis_valid: got %b required 0", timing_valid); else n_pass++;
        n_checks++; if (frame_width !== 12'd10) $display("FAIL mis_frame_width: got %0d required 10", frame_width); else n_pass++;
        n_checks++; if (frame_height !== 12'd6) $display("FAIL mis_frame_height: got %0d required 6", frame_height); else n_pass++;
        run_frame(6, 10, -1, 0, 24'h0F0F0F);
        vsync_pulse(24'h0F0F0F);
        n_checks++; if (timing_valid !== 1'b1) $display("FAIL mis_recover_valid: got %b required 1", timing_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        drv_mode = 2'd1;
        run_frame(2, 8, -1, 0, 24'h112233);
        vsync_pulse(24'h112233);
        run_frame(3, 8, -1, 0, 24'h112233);
        repeat (4) step(3'b001, 24'h112233);
        #2;
        sb_en   = 1'b0;
        reset_n = 1'b0;
        #1;
        n_checks++; if (sync_out !== 3'b000) $display("FAIL mid_sync_out: got %b required 000", sync_out); else n_pass++;
        n_checks++; if (rgb_out !== 24'h0) $display("FAIL mid_rgb_out: got %h required 000000", rgb_out); else n_pass++;
        n_checks++; if (active_mode !== 2'd0) $display("FAIL mid_active_mode: got %0d required 0", active_mode); else n_pass++;
        n_checks++; if (frame_width !== 12'd0) $display("FAIL mid_frame_width: got %0d required 0", frame_width); else n_pass++;
        n_checks++; if (frame_height !== 12'd0) $display("FAIL mid_frame_height: got %0d required 0", frame_height); else n_pass++;
        n_checks++; if (timing_valid !== 1'b0) $display("FAIL mid_valid: got %b required 0", timing_valid); else n_pass++;
        release_reset();
        line(4, 24'h112233);
        line(8, 24'h112233);
        n_checks++; if (active_mode !== 2'd0) $display("FAIL mid_mode_after_rst: got %0d required 0", active_mode); else n_pass++;
        vsync_pulse(24'h112233);
        n_checks++; if (frame_height !== 12'd2) $display("FAIL mid_partial_height: got %0d required 2", frame_height); else n_pass++;
        n_checks++; if (frame_width !== 12'd4) $display("FAIL mid_partial_width: got %0d required 4", frame_width); else n_pass++;
        n_checks++; if (timing_valid !== 1'b0) $display("FAIL mid_partial_valid: got %b required 0", timing_valid); else n_pass++;
        n_checks++; if (active_mode !== 2'd1) $display("FAIL mid_mode_reload: got %0d required 1", active_mode); else n_pass++;
        line(8, 24'h112233);
    endtask

    initial begin
        reset_n     = 1'b0;
        mode        = 2'd0;
        fill_colour = '0;
        sync_in     = '0;
        rgb_in      = '0;
        test_reset();
        test_pass();
        test_invert();
        test_ramp_fill();
        test_timing();
        test_mismatch();
        test_reset_mid();
        repeat (PD + 1) step(3'b000, 24'h0);
        @(negedge p_clock);
        #1;
        n_checks++;
        if (sb.size() > PD) $display("FAIL sb_drain: got %0d pending required <= %0d", sb.size(), PD);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
